// File: rtl/s2p_fifo_with_params.sv
// s2p_fifo_with_params: serial-to-parallel word assembler feeding a small FIFO.
// A 1-bit valid/ready stream is gathered into FIFO_WIDTH-bit words. Each
// completed word is written into a FIFO_DEPTH-entry buffer, and the consumer
// drains that buffer through pop/pop_data/empty/full/level.
// Optional feature macro: S2P_PARITY_EN. When it is defined, each frame
// carries one trailing even-parity bit. Only words that pass the parity check
// are stored; a failing word is dropped and par_err pulses for one cycle.
module s2p_fifo_with_params #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_WIDTH = 11,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ser_valid,
  input  logic                          ser_data,
  output logic                          ser_ready,
  input  logic                          pop,
  output logic [FIFO_WIDTH-1:0]         pop_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          par_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (FIFO_WIDTH > 2) ? $clog2(FIFO_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FIFO_WIDTH - 1);
`ifdef S2P_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic {S_DATA = 1'b0, S_PAR = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FIFO_WIDTH-1:0] shreg_q, shreg_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [FIFO_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  par_err_q, par_err_d;
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  accept;
  logic                  last_bit;
  logic                  push;
  logic                  pop_ok;
  logic                  par_fail;
  logic [FIFO_WIDTH-1:0] shifted;
  logic [FIFO_WIDTH-1:0] push_word;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign level     = level_q;
  assign pop_data  = pop_data_q;
  assign par_err   = par_err_q;

  // The next accepted bit completes a frame: the parity bit if it is enabled, else the last data bit.
  assign last_bit  = PAR_EN ? (state_q == S_PAR)
                            : ((state_q == S_DATA) && (cnt_q == CNT_LAST));
  // Stall only the completing bit while there is no room. Earlier bits can still be accepted.
  assign ser_ready = !(full && last_bit);
  assign accept    = ser_valid && ser_ready;

  // Framing FSM: shift in data bits, then check parity if it is enabled, and decide whether to push.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    par_fail  = 1'b0;
    if (LSB_FIRST) shifted = {ser_data, shreg_q[FIFO_WIDTH-1:1]};
    else           shifted = {shreg_q[FIFO_WIDTH-2:0], ser_data};
    push_word = shifted;
    if (accept) begin
      case (state_q)
        S_DATA: begin
          shreg_d = shifted;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (PAR_EN) state_d = S_PAR;
            else        push    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PAR: begin
          state_d   = S_DATA;
          push_word = shreg_q;
          // Even parity: the data bits and the parity bit XOR to zero.
          if (^{shreg_q, ser_data}) par_fail = 1'b1;
          else                      push     = 1'b1;
        end
        default: state_d = S_DATA;
      endcase
    end
    par_err_d = PAR_EN ? par_fail : 1'b0;
  end

  // FIFO bookkeeping: level is the only source of empty/full, and pop_data is loaded only on a real pop.
  always_comb begin
    pop_ok     = pop && !empty;
    wptr_d     = push   ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop_ok ? rptr_q + AW'(1) : rptr_q;
    level_d    = level_q + LW'(push) - LW'(pop_ok);
    pop_data_d = pop_ok ? mem_q[rptr_q] : pop_data_q;
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_DATA;
      cnt_q      <= '0;
      shreg_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      pop_data_q <= '0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      pop_data_q <= pop_data_d;
      par_err_q  <= par_err_d;
    end
  end

  // Storage array. It has no reset because it is only read behind a valid level count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_word;
  end

endmodule

// File: tb/tb_s2p_fifo_with_params.sv
// Directed testbench for s2p_fifo_with_params using the default parameters.
// It also covers the S2P_PARITY_EN build when that macro is defined.
module tb_s2p_fifo_with_params;

  localparam int W = 11;
  localparam int D = 8;
  localparam bit LSBF = 1'b1;
`ifdef S2P_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic         ser_valid;
  logic         ser_data;
  logic         ser_ready;
  logic         pop;
  logic [W-1:0] pop_data;
  logic         empty;
  logic         full;
  logic [3:0]   level;
  logic         par_err;

  int n_cmp = 0;
  int n_err = 0;

  s2p_fifo_with_params #(.FIFO_DEPTH(D), .FIFO_WIDTH(W), .LSB_FIRST(LSBF)) dut (
    .clk(clk), .rstn(rstn), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready), .pop(pop), .pop_data(pop_data), .empty(empty),
    .full(full), .level(level), .par_err(par_err)
  );

  always #5 clk = ~clk;

  // Frame bit i of word v. Index W is the correct even-parity bit.
  function automatic logic frame_bit(input logic [W-1:0] v, input int i);
    if (i >= W) return ^v;
    return LSBF ? v[i] : v[W-1-i];
  endfunction

  task automatic send_bit(input logic b);
    int t;
    ser_valid = 1'b1;
    ser_data  = b;
    t = 0;
    while (!ser_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ser_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: ser_ready=%0b required 1", ser_ready);
    end
    @(posedge clk); #1;
    ser_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] v, input int from, input int to, input bit gaps);
    for (int i = from; i <= to; i++) begin
      send_bit(frame_bit(v, i));
      if (gaps && (i % 3 == 0)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_pop();
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ser_valid = 1'b0; ser_data = 1'b0; pop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pop_data !== 11'h000) begin n_err++; $display("FAIL rst_pop_data: got %h want 000", pop_data); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL rst_flags: empty=%b full=%b want 1/0", empty, full); end
    n_cmp++; if (level !== 4'd0 || par_err !== 1'b0) begin n_err++; $display("FAIL rst_level: level=%0d par_err=%b want 0/0", level, par_err); end
    rstn = 1'b1;
    @(posedge clk); #1;
    send_bits(11'h7FF, 0, 4, 1'b0);
    #2 rstn = 1'b0;
    #2;
    n_cmp++; if (empty !== 1'b1 || level !== 4'd0 || ser_ready !== 1'b1) begin
      n_err++; $display("FAIL midword_rst: empty=%b level=%0d ready=%b want 1/0/1", empty, level, ser_ready);
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    send_bits(11'h3C5, 0, FRAME-2, 1'b0);
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL fresh_word_partial: level=%0d want 0", level); end
    send_bits(11'h3C5, FRAME-1, FRAME-1, 1'b0);
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL fresh_word_push: level=%0d want 1", level); end
    do_pop();
    n_cmp++; if (pop_data !== 11'h3C5) begin n_err++; $display("FAIL fresh_word_data: got %h want 3c5", pop_data); end
  endtask

  task automatic test_single_word();
    send_bits(11'h5A3, 0, FRAME-1, 1'b1);
    n_cmp++; if (empty !== 1'b0 || level !== 4'd1) begin n_err++; $display("FAIL single_push: empty=%b level=%0d want 0/1", empty, level); end
    do_pop();
    n_cmp++; if (pop_data !== 11'h5A3) begin n_err++; $display("FAIL single_data: got %h want 5a3", pop_data); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: empty=%b want 1", empty); end
  endtask

  task automatic test_fill_stall();
    logic [W-1:0] v;
    int bad;
    for (int k = 0; k < D; k++) begin
      v = W'(k);
      send_bits(v, 0, FRAME-1, 1'b0);
    end
    n_cmp++; if (full !== 1'b1 || level !== 4'd8) begin n_err++; $display("FAIL fill_full: full=%b level=%0d want 1/8", full, level); end
    bad = 0;
    for (int i = 0; i <= FRAME-2; i++) begin
      if (ser_ready !== 1'b1) bad++;
      send_bit(frame_bit(11'h2AB, i));
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_early_ready: %0d low cycles want 0", bad); end
    ser_valid = 1'b1; ser_data = frame_bit(11'h2AB, FRAME-1);
    #1;
    n_cmp++; if (ser_ready !== 1'b0) begin n_err++; $display("FAIL stall_last_ready: ready=%b want 0", ser_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL stall_hold: level=%0d want 8", level); end
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    n_cmp++; if (pop_data !== 11'h000 || level !== 4'd7 || ser_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_release: data=%h level=%0d ready=%b want 000/7/1", pop_data, level, ser_ready);
    end
    @(posedge clk); #1;
    ser_valid = 1'b0;
    n_cmp++; if (full !== 1'b1 || level !== 4'd8) begin n_err++; $display("FAIL stall_refill: full=%b level=%0d want 1/8", full, level); end
    for (int k = 1; k < D; k++) begin
      do_pop();
      n_cmp++; if (pop_data !== W'(k)) begin n_err++; $display("FAIL drain_%0d: got %h want %h", k, pop_data, W'(k)); end
    end
    do_pop();
    n_cmp++; if (pop_data !== 11'h2AB || empty !== 1'b1) begin n_err++; $display("FAIL drain_last: got %h empty=%b want 2ab/1", pop_data, empty); end
  endtask

  task automatic test_wrap_order();
    logic [W-1:0] got [20];
    int n, lvl_bad;
    bit p;
    n = 0; lvl_bad = 0;
    fork
      begin
        for (int k = 1; k <= 20; k++) send_bits(W'(k), 0, FRAME-1, (k % 4) == 0);
      end
      begin
        for (int c = 0; c < 4000 && n < 20; c++) begin
          pop = !empty;
          p = pop;
          @(posedge clk); #1;
          if (p) begin got[n] = pop_data; n++; end
          if (level > 4'd8) lvl_bad++;
        end
        pop = 1'b0;
      end
    join
    n_cmp++; if (n != 20) begin n_err++; $display("FAIL wrap_count: got %0d words want 20", n); end
    n_cmp++; if (lvl_bad != 0) begin n_err++; $display("FAIL wrap_level: %0d cycles over 8 want 0", lvl_bad); end
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (got[i] !== W'(i + 1)) begin n_err++; $display("FAIL wrap_word_%0d: got %h want %h", i, got[i], W'(i + 1)); end
    end
  endtask

  task automatic test_edges();
    do_pop();
    n_cmp++; if (pop_data !== 11'd20 || level !== 4'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL empty_pop: data=%h level=%0d want 014/0", pop_data, level);
    end
    send_bits(11'h111, 0, FRAME-1, 1'b0);
    send_bits(11'h6CE, 0, FRAME-2, 1'b0);
    ser_valid = 1'b1; ser_data = frame_bit(11'h6CE, FRAME-1); pop = 1'b1;
    @(posedge clk); #1;
    ser_valid = 1'b0; pop = 1'b0;
    n_cmp++; if (level !== 4'd1 || pop_data !== 11'h111) begin
      n_err++; $display("FAIL push_pop_same: level=%0d data=%h want 1/111", level, pop_data);
    end
    do_pop();
    n_cmp++; if (pop_data !== 11'h6CE || empty !== 1'b1) begin n_err++; $display("FAIL push_pop_next: got %h empty=%b want 6ce/1", pop_data, empty); end
  endtask

`ifdef S2P_PARITY_EN
  task automatic test_parity();
    send_bits(11'h001, 0, W, 1'b0);
    n_cmp++; if (level !== 4'd1 || par_err !== 1'b0) begin n_err++; $display("FAIL par_good: level=%0d par_err=%b want 1/0", level, par_err); end
    send_bits(11'h001, 0, W-1, 1'b0);
    send_bit(1'b0);
    n_cmp++; if (par_err !== 1'b1 || level !== 4'd1) begin n_err++; $display("FAIL par_bad: par_err=%b level=%0d want 1/1", par_err, level); end
    @(posedge clk); #1;
    n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_pulse: par_err=%b want 0", par_err); end
    send_bits(11'h0F0, 0, W, 1'b0);
    n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL par_reframe: level=%0d want 2", level); end
    do_pop();
    n_cmp++; if (pop_data !== 11'h001) begin n_err++; $display("FAIL par_data0: got %h want 001", pop_data); end
    do_pop();
    n_cmp++; if (pop_data !== 11'h0F0) begin n_err++; $display("FAIL par_data1: got %h want 0f0", pop_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_fill_stall();
    test_wrap_order();
    test_edges();
`ifdef S2P_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
